// File: rtl/cp0_exc.sv
// MIPS-style CP0 exception unit: Status/Cause/EPC registers, event priority and pipeline redirect.
// Optional Count/Compare timer is built when macro CP0_TIMER_EN is defined.
module cp0_exc #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic        ex_in_delay,
  input  logic        ex_overflow,
  input  logic        ex_ri,
  input  logic        ex_syscall,
  input  logic        ex_break,
  input  logic        ex_eret,
  input  logic        ex_mtc0,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  input  logic [5:0]  hw_int,
  output logic        flush,
  output logic [31:0] exc_pc
);

  localparam logic [4:0] ADDR_COUNT   = 5'd9;
  localparam logic [4:0] ADDR_COMPARE = 5'd11;
  localparam logic [4:0] ADDR_STATUS  = 5'd12;
  localparam logic [4:0] ADDR_CAUSE   = 5'd13;
  localparam logic [4:0] ADDR_EPC     = 5'd14;

  localparam logic [4:0] CODE_INT = 5'h00;
  localparam logic [4:0] CODE_RI  = 5'h0A;
  localparam logic [4:0] CODE_OV  = 5'h0C;
  localparam logic [4:0] CODE_SYS = 5'h08;
  localparam logic [4:0] CODE_BP  = 5'h09;

  logic [7:0]  r_im;
  logic        r_exl;
  logic        r_ie;
  logic        r_bd;
  logic [5:0]  r_ip_hw;
  logic [1:0]  r_ip_sw;
  logic [4:0]  r_exccode;
  logic [31:0] r_epc;

  logic        w_ti;
  logic [7:0]  w_ip;
  logic [31:0] w_status;
  logic [31:0] w_cause;
  logic        w_int_pend;
  logic        w_exc;
  logic [4:0]  w_code;
  logic        w_eret;
  logic        w_mtc0;

  // The timer interrupt shares IP7 with hw_int[5].
  assign w_ip     = {r_ip_hw[5] | w_ti, r_ip_hw[4:0], r_ip_sw};
  assign w_status = {9'd0, 1'b1, 6'd0, r_im, 6'd0, r_exl, r_ie};
  assign w_cause  = {r_bd, w_ti, 14'd0, w_ip, 1'b0, r_exccode, 2'b00};

  assign w_int_pend = r_ie & ~r_exl & (|(w_ip & r_im)) & ex_valid;

  always_comb begin
    w_exc  = 1'b1;
    w_code = CODE_INT;
    if (w_int_pend) begin
      w_code = CODE_INT;
    end else if (ex_valid && ex_ri) begin
      w_code = CODE_RI;
    end else if (ex_valid && ex_overflow) begin
      w_code = CODE_OV;
    end else if (ex_valid && ex_syscall) begin
      w_code = CODE_SYS;
    end else if (ex_valid && ex_break) begin
      w_code = CODE_BP;
    end else begin
      w_exc = 1'b0;
    end
  end

  assign w_eret = ex_valid & ex_eret & ~w_exc;
  assign w_mtc0 = ex_valid & ex_mtc0 & ~w_exc & ~w_eret;

  always_comb begin
    flush  = 1'b0;
    exc_pc = 32'd0;
    if (!rst) begin
      if (w_exc) begin
        flush  = 1'b1;
        exc_pc = EXC_VECTOR;
      end else if (w_eret) begin
        flush  = 1'b1;
        exc_pc = r_epc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_im      <= 8'd0;
      r_exl     <= 1'b0;
      r_ie      <= 1'b0;
      r_bd      <= 1'b0;
      r_ip_hw   <= 6'd0;
      r_ip_sw   <= 2'd0;
      r_exccode <= 5'd0;
      r_epc     <= 32'd0;
    end else begin
      r_ip_hw <= hw_int;
      if (w_exc) begin
        r_exccode <= w_code;
        // A nested exception keeps the original return address.
        if (!r_exl) begin
          r_epc <= ex_in_delay ? (ex_pc - 32'd4) : ex_pc;
          r_bd  <= ex_in_delay;
          r_exl <= 1'b1;
        end
      end else if (w_eret) begin
        r_exl <= 1'b0;
      end else if (w_mtc0) begin
        case (cp0_addr)
          ADDR_STATUS: begin
            r_im  <= cp0_wdata[15:8];
            r_exl <= cp0_wdata[1];
            r_ie  <= cp0_wdata[0];
          end
          ADDR_CAUSE: r_ip_sw <= cp0_wdata[9:8];
          ADDR_EPC:   r_epc   <= cp0_wdata;
          default: ;
        endcase
      end
    end
  end

`ifdef CP0_TIMER_EN
  logic [31:0] r_count;
  logic [31:0] r_compare;
  logic        r_tick;
  logic        r_ti;

  assign w_ti = r_ti;

  // Count advances on every second cycle; software writes take precedence.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count   <= 32'd0;
      r_compare <= 32'd0;
      r_tick    <= 1'b0;
      r_ti      <= 1'b0;
    end else begin
      r_tick <= ~r_tick;
      if (w_mtc0 && (cp0_addr == ADDR_COUNT)) begin
        r_count <= cp0_wdata;
      end else if (r_tick) begin
        r_count <= r_count + 32'd1;
      end
      if (w_mtc0 && (cp0_addr == ADDR_COMPARE)) begin
        r_compare <= cp0_wdata;
        r_ti      <= 1'b0;
      end else if (r_count == r_compare) begin
        r_ti <= 1'b1;
      end
    end
  end

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_COUNT:   cp0_rdata = r_count;
      ADDR_COMPARE: cp0_rdata = r_compare;
      ADDR_STATUS:  cp0_rdata = w_status;
      ADDR_CAUSE:   cp0_rdata = w_cause;
      ADDR_EPC:     cp0_rdata = r_epc;
      default:      cp0_rdata = 32'd0;
    endcase
  end
`else
  assign w_ti = 1'b0;

  always_comb begin
    cp0_rdata = 32'd0;
    case (cp0_addr)
      ADDR_STATUS: cp0_rdata = w_status;
      ADDR_CAUSE:  cp0_rdata = w_cause;
      ADDR_EPC:    cp0_rdata = r_epc;
      default:     cp0_rdata = 32'd0;
    endcase
  end
`endif

endmodule

// File: tb/tb_cp0_exc.sv
// Scoreboard bench for cp0_exc: stimulus queues expected redirect/read values, a negedge monitor checks them.
// Timer checks are included when CP0_TIMER_EN is defined.
module tb_cp0_exc;

  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic        ex_in_delay;
  logic        ex_overflow;
  logic        ex_ri;
  logic        ex_syscall;
  logic        ex_break;
  logic        ex_eret;
  logic        ex_mtc0;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [5:0]  hw_int;
  logic        flush;
  logic [31:0] exc_pc;

  cp0_exc dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_pc      (ex_pc),
    .ex_in_delay(ex_in_delay),
    .ex_overflow(ex_overflow),
    .ex_ri      (ex_ri),
    .ex_syscall (ex_syscall),
    .ex_break   (ex_break),
    .ex_eret    (ex_eret),
    .ex_mtc0    (ex_mtc0),
    .cp0_addr   (cp0_addr),
    .cp0_wdata  (cp0_wdata),
    .cp0_rdata  (cp0_rdata),
    .hw_int     (hw_int),
    .flush      (flush),
    .exc_pc     (exc_pc)
  );

  localparam logic [4:0] EV_NONE = 5'b00000;
  localparam logic [4:0] EV_RI   = 5'b10000;
  localparam logic [4:0] EV_OV   = 5'b01000;
  localparam logic [4:0] EV_SYS  = 5'b00100;
  localparam logic [4:0] EV_BRK  = 5'b00010;
  localparam logic [4:0] EV_ERET = 5'b00001;
  localparam logic [31:0] VEC    = 32'hBFC0_0380;

  typedef struct {
    logic        expFlush;
    logic [31:0] expPc;
    logic        isRead;
    logic [31:0] expRd;
    string       name;
  } exp_t;

  exp_t sbQ[$];
  logic stimStrobe;
  int   total;
  int   bad;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one scoreboard entry per stimulus cycle, unexpected redirects flagged otherwise.
  always @(negedge clk) begin
    if (stimStrobe) begin
      if (sbQ.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL scoreboard_underflow: queue empty, required one entry");
      end else begin
        exp_t e;
        logic [31:0] wantPc;
        e = sbQ.pop_front();
        wantPc = e.expFlush ? e.expPc : 32'd0;
        total++;
        if (flush !== e.expFlush) begin
          bad++;
          $display("[TB] FAIL %s.flush: got %0b, required %0b", e.name, flush, e.expFlush);
        end
        total++;
        if (exc_pc !== wantPc) begin
          bad++;
          $display("[TB] FAIL %s.exc_pc: got %08h, required %08h", e.name, exc_pc, wantPc);
        end
        if (e.isRead) begin
          total++;
          if (cp0_rdata !== e.expRd) begin
            bad++;
            $display("[TB] FAIL %s.rdata: got %08h, required %08h", e.name, cp0_rdata, e.expRd);
          end
        end
      end
    end else if (flush !== 1'b0) begin
      total++;
      bad++;
      $display("[TB] FAIL idle_flush: got %0b, required 0", flush);
    end
  end

  task automatic applyStimulus(input logic valid, input logic [31:0] pc, input logic dly,
                               input logic [4:0] ev, input logic mtc0, input logic [4:0] addr,
                               input logic [31:0] wdata, input logic expFlush,
                               input logic [31:0] expPc, input string name);
    exp_t e;
    ex_valid    = valid;
    ex_pc       = pc;
    ex_in_delay = dly;
    ex_ri       = ev[4];
    ex_overflow = ev[3];
    ex_syscall  = ev[2];
    ex_break    = ev[1];
    ex_eret     = ev[0];
    ex_mtc0     = mtc0;
    cp0_addr    = addr;
    cp0_wdata   = wdata;
    e.expFlush  = expFlush;
    e.expPc     = expPc;
    e.isRead    = 1'b0;
    e.expRd     = 32'd0;
    e.name      = name;
    sbQ.push_back(e);
    stimStrobe  = 1'b1;
    @(posedge clk);
    #1;
    stimStrobe  = 1'b0;
    ex_valid    = 1'b0;
    ex_ri       = 1'b0;
    ex_overflow = 1'b0;
    ex_syscall  = 1'b0;
    ex_break    = 1'b0;
    ex_eret     = 1'b0;
    ex_mtc0     = 1'b0;
    ex_in_delay = 1'b0;
  endtask

  task automatic checkOutput(input logic [4:0] addr, input logic [31:0] expRd, input string name);
    exp_t e;
    cp0_addr   = addr;
    e.expFlush = 1'b0;
    e.expPc    = 32'd0;
    e.isRead   = 1'b1;
    e.expRd    = expRd;
    e.name     = name;
    sbQ.push_back(e);
    stimStrobe = 1'b1;
    @(posedge clk);
    #1;
    stimStrobe = 1'b0;
  endtask

  task automatic writeCp0(input logic [4:0] addr, input logic [31:0] data, input string name);
    applyStimulus(1'b1, 32'h8000_0000, 1'b0, EV_NONE, 1'b1, addr, data, 1'b0, 32'd0, name);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++)
      applyStimulus(1'b0, 32'd0, 1'b0, EV_NONE, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, "idle");
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    total = 0;
    bad = 0;
    stimStrobe = 1'b0;
    rst = 1'b1;
    ex_valid = 1'b0; ex_pc = 32'd0; ex_in_delay = 1'b0; ex_overflow = 1'b0;
    ex_ri = 1'b0; ex_syscall = 1'b0; ex_break = 1'b0; ex_eret = 1'b0;
    ex_mtc0 = 1'b0; cp0_addr = 5'd0; cp0_wdata = 32'd0; hw_int = 6'd0;

    @(posedge clk);
    #1;
    // Exception and mtc0 under reset must neither redirect nor change state.
    applyStimulus(1'b1, 32'h8000_0100, 1'b0, EV_OV, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, "rst_ov");
    applyStimulus(1'b1, 32'h8000_0100, 1'b0, EV_NONE, 1'b1, 5'd14, 32'hDEAD_BEEF, 1'b0, 32'd0, "rst_mtc0");
    rst = 1'b0;
`ifdef CP0_TIMER_EN
    writeCp0(5'd11, 32'hFFFF_FFFF, "park_compare");
`endif
    checkOutput(5'd12, 32'h0040_0000, "reset_status");
    checkOutput(5'd13, 32'h0000_0000, "reset_cause");
    checkOutput(5'd14, 32'h0000_0000, "reset_epc");

    applyStimulus(1'b1, 32'h8000_0100, 1'b0, EV_OV, 1'b0, 5'd0, 32'd0, 1'b1, VEC, "ov");
    checkOutput(5'd14, 32'h8000_0100, "ov_epc");
    checkOutput(5'd13, 32'h0000_0030, "ov_cause");
    checkOutput(5'd12, 32'h0040_0002, "ov_status");

    applyStimulus(1'b0, 32'h8000_0180, 1'b0, EV_SYS, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, "invalid_sys");
    checkOutput(5'd13, 32'h0000_0030, "invalid_cause");

    writeCp0(5'd14, 32'h8000_0300, "set_epc");
    checkOutput(5'd14, 32'h8000_0300, "set_epc_rd");
    applyStimulus(1'b1, 32'h8000_0110, 1'b0, EV_ERET, 1'b0, 5'd0, 32'd0, 1'b1, 32'h8000_0300, "eret");
    checkOutput(5'd12, 32'h0040_0000, "eret_status");

    applyStimulus(1'b1, 32'h8000_0204, 1'b1, EV_SYS, 1'b0, 5'd0, 32'd0, 1'b1, VEC, "sys_delay");
    checkOutput(5'd14, 32'h8000_0200, "sys_epc");
    checkOutput(5'd13, 32'h8000_0020, "sys_cause");

    applyStimulus(1'b1, 32'h8000_0500, 1'b0, EV_BRK, 1'b0, 5'd0, 32'd0, 1'b1, VEC, "nested_brk");
    checkOutput(5'd14, 32'h8000_0200, "nested_epc");
    checkOutput(5'd13, 32'h8000_0024, "nested_cause");

    applyStimulus(1'b1, 32'h8000_0510, 1'b0, EV_OV | EV_ERET, 1'b0, 5'd0, 32'd0, 1'b1, VEC, "eret_ov");
    checkOutput(5'd12, 32'h0040_0002, "eret_ov_status");
    checkOutput(5'd13, 32'h8000_0030, "eret_ov_cause");
    applyStimulus(1'b1, 32'h8000_0520, 1'b0, EV_ERET, 1'b0, 5'd0, 32'd0, 1'b1, 32'h8000_0200, "eret2");

    applyStimulus(1'b1, 32'h8000_0600, 1'b0, EV_BRK, 1'b1, 5'd14, 32'h1234_5678, 1'b1, VEC, "brk_mtc0");
    checkOutput(5'd14, 32'h8000_0600, "brk_mtc0_epc");
    checkOutput(5'd13, 32'h0000_0024, "brk_cause");
    applyStimulus(1'b1, 32'h8000_0610, 1'b0, EV_ERET, 1'b0, 5'd0, 32'd0, 1'b1, 32'h8000_0600, "eret3");

    writeCp0(5'd12, 32'h0000_0401, "set_status");
    checkOutput(5'd12, 32'h0040_0401, "status_rd");
    hw_int = 6'b000001;
    idleCycles(1);
    checkOutput(5'd13, 32'h0000_0424, "ip_latched");
    applyStimulus(1'b1, 32'h8000_0700, 1'b0, EV_RI, 1'b0, 5'd0, 32'd0, 1'b1, VEC, "int_vs_ri");
    checkOutput(5'd13, 32'h0000_0400, "int_cause");
    checkOutput(5'd14, 32'h8000_0700, "int_epc");
    applyStimulus(1'b1, 32'h8000_0710, 1'b0, EV_NONE, 1'b0, 5'd0, 32'd0, 1'b0, 32'd0, "int_masked_exl");
    hw_int = 6'd0;

    writeCp0(5'd5, 32'hFFFF_FFFF, "unmapped_wr");
    checkOutput(5'd5, 32'h0000_0000, "unmapped_rd");
    writeCp0(5'd13, 32'hFFFF_FFFF, "cause_wr");
    checkOutput(5'd13, 32'h0000_0300, "cause_rw_bits");
    writeCp0(5'd12, 32'hFFFF_FFFF, "status_wr");
    checkOutput(5'd12, 32'h0040_FF03, "status_rw_bits");

`ifdef CP0_TIMER_EN
    rst = 1'b1;
    idleCycles(1);
    rst = 1'b0;
    writeCp0(5'd11, 32'd4, "cmp4");
    checkOutput(5'd13, 32'h0000_0000, "ti_clear_start");
    idleCycles(10);
    checkOutput(5'd13, 32'h4000_8000, "ti_set");
    writeCp0(5'd11, 32'd100, "cmp100");
    checkOutput(5'd13, 32'h0000_0000, "ti_cleared");
    checkOutput(5'd11, 32'd100, "compare_rd");
`else
    checkOutput(5'd9, 32'h0000_0000, "no_count");
    checkOutput(5'd11, 32'h0000_0000, "no_compare");
`endif

    idleCycles(2);
    if (sbQ.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL scoreboard_leftover: %0d entries left, required 0", sbQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
